// File: rtl/seg_mux_display.sv
// seg_mux_display: valid/ready binary-to-BCD (double dabble) converter driving a multiplexed seven-segment display.
// Optional SEG_BRIGHTNESS_EN adds a 3-bit brightness input that PWM-gates the selected anode.
module seg_mux_display #(
    parameter int NUM_DIGITS       = 4,
    parameter int VALUE_W          = 14,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int BLANK_LEADING    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  value_valid,
    input  logic [VALUE_W-1:0]    value,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [2:0]            brightness,
`endif
    output logic                  value_ready,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);
    function automatic int pow10_m1(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    localparam int MAX_VAL = pow10_m1(NUM_DIGITS);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                  state, state_nx;
    logic [VALUE_W-1:0]      bin, sat_val;
    logic [BW-1:0]           bcd, adj, disp;
    logic [BW+VALUE_W-1:0]   sh;
    logic [CW-1:0]           cnt;
    logic                    over, accept, on, blank;
    logic [IW-1:0]           idx;
    logic [NUM_DIGITS-1:0]   sel;
    logic [NUM_DIGITS:0]     zh;
    logic [6:0]              seg_q;
    logic [3:0]              cur;

    assign over    = 32'(value) > 32'(MAX_VAL);
    assign sat_val = over ? VALUE_W'(MAX_VAL) : value;
    assign accept  = value_valid && value_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = state == IDLE  ? (value_valid ? SHIFT : IDLE) :
                   state == SHIFT ? (cnt == CW'(VALUE_W - 1) ? LOAD : SHIFT) : IDLE;

    always_comb value_ready = state == IDLE;

    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    assign sh = {adj, bin} << 1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                bin      <= sat_val;
                bcd      <= '0;
                cnt      <= '0;
                overflow <= over;
            end
            if (state == SHIFT) begin
                {bcd, bin} <= sh;
                cnt        <= cnt + 1'b1;
            end
            if (state == LOAD) disp <= bcd;
        end

    // zh[i] is set when nibble i and every nibble above it are zero
    always_comb begin
        zh = '0;
        zh[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zh[i] = zh[i+1] && disp[4*i +: 4] == 4'd0;
    end

    assign cur   = disp[idx*4 +: 4];
    assign blank = BLANK_LEADING != 0 && idx != '0 && zh[idx];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx   <= '0;
            sel   <= '0;
            seg_q <= '0;
        end else if (tick) begin
            idx   <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            sel   <= NUM_DIGITS'(1) << idx;
            seg_q <= blank ? 7'h00 : dec(cur);
        end

`ifdef SEG_BRIGHTNESS_EN
    logic [2:0] pwm_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 3'd1;
    assign on = pwm_cnt <= brightness;
`else
    assign on = 1'b1;
`endif

    assign an  = ANODE_ACTIVE_LOW != 0 ? ~(sel & {NUM_DIGITS{on}}) : sel & {NUM_DIGITS{on}};
    assign seg = SEG_ACTIVE_LOW != 0 ? ~seg_q : seg_q;
endmodule
